// File: rtl/vga_pkg.sv
// VGA timing shared definitions: coordinate width, default 640x480@60 timing
// constants, region-state enum and the wrapping-increment helper.
package vga_pkg;

    localparam int CW = 10;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Shared by both axes; the vertical FSM reuses the same encoding.
    typedef enum logic [1:0] {
        H_ACT,
        H_FRONT,
        H_SYNC_ST,
        H_BACK
    } region_t;

    // Wrap is decided by equality with the last value, never by overflow.
    function automatic logic [CW-1:0] wrap_next(
        input logic [CW-1:0] cnt,
        input logic [CW-1:0] last
    );
        return (cnt == last) ? '0 : cnt + CW'(1);
    endfunction

endpackage

// File: rtl/timing_counter.sv
// One timing axis: wrapping counter with enable, terminal-count flag and
// region FSM. Ports: clk, rst, en -> cnt, tc (cnt==TOTAL-1), region.
module timing_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          tc,
    output region_t       region
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);
    localparam logic [CW-1:0] FRONT_AT = CW'(ACTIVE);
    localparam logic [CW-1:0] SYNC_AT  = CW'(ACTIVE + FP);
    localparam logic [CW-1:0] BACK_AT  = CW'(ACTIVE + FP + SYNC);

    logic [CW-1:0] nxt;

    assign tc  = (cnt == LAST);
    assign nxt = wrap_next(cnt, LAST);

    // Region moves together with the count, so region always describes cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            region <= H_ACT;
        end else if (en) begin
            cnt <= nxt;
            unique case (region)
                H_ACT:     if (nxt == FRONT_AT) region <= H_FRONT;
                H_FRONT:   if (nxt == SYNC_AT)  region <= H_SYNC_ST;
                H_SYNC_ST: if (nxt == BACK_AT)  region <= H_BACK;
                H_BACK:    if (tc)              region <= H_ACT;
                default:                        region <= H_ACT;
            endcase
        end
    end

endmodule

// File: rtl/vga_timing.sv
// VGA sync generator: x/y counters, video_on, active-low hsync/vsync and
// frame/line start pulses, all registered one clk after counter state.
// Ports: clk, rst (sync, active-high) -> x, y, video_on, hsync, vsync,
// frame_start, line_start. Macro VGA_TIMING_PIX_DIV_EN: pixel enable on
// every second clk; undefined: every clk is a pixel.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic          clk,
    input  logic          rst,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          video_on,
    output logic          hsync,
    output logic          vsync,
    output logic          frame_start,
    output logic          line_start
);

    logic          pix_en;
    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic          h_tc;
    logic          unused_v_tc;
    region_t       h_region;
    region_t       v_region;

`ifdef VGA_TIMING_PIX_DIV_EN
    logic div_q;

    // Cleared in reset so the first clk after release is a pixel clk.
    always_ff @(posedge clk) begin
        if (rst) div_q <= 1'b0;
        else     div_q <= ~div_q;
    end

    assign pix_en = ~div_q;
`else
    assign pix_en = 1'b1;
`endif

    timing_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h (
        .clk    (clk),
        .rst    (rst),
        .en     (pix_en),
        .cnt    (h_cnt),
        .tc     (h_tc),
        .region (h_region)
    );

    timing_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v (
        .clk    (clk),
        .rst    (rst),
        .en     (pix_en & h_tc),
        .cnt    (v_cnt),
        .tc     (unused_v_tc),
        .region (v_region)
    );

    // Outputs capture only on pixel clks, so the start pulses are one clk
    // wide even when a pixel spans several clks.
    always_ff @(posedge clk) begin
        if (rst) begin
            x           <= '0;
            y           <= '0;
            video_on    <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else if (pix_en) begin
            x           <= h_cnt;
            y           <= v_cnt;
            video_on    <= (h_region == H_ACT) && (v_region == H_ACT);
            hsync       <= (h_region != H_SYNC_ST);
            vsync       <= (v_region != H_SYNC_ST);
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
            line_start  <= (h_cnt == '0);
        end else begin
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end
    end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 Parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 Parameters V_ACTIVE 480, V_FP 10, V_SYNC 2 and V_BP 33 (lines) SHALL be the vertical equivalents.
REQ-006 Port clk  input  1  system clock; one clock domain, all logic rising-edge.
REQ-007 Port rst  input  1  synchronous, active-high reset.
REQ-008 Port x  output  10  current horizontal pixel count, 0..H_TOTAL-1, to sprite stages.
REQ-009 Port y  output  10  current line count, 0..V_TOTAL-1, to sprite stages.
REQ-010 Port video_on  output  1  high when x<H_ACTIVE and y<V_ACTIVE.
REQ-011 Port hsync  output  1  horizontal sync, active-low.
REQ-012 Port vsync  output  1  vertical sync, active-low.
REQ-013 Port frame_start  output  1  one-clk pulse when (x,y) becomes (0,0).
REQ-014 Port line_start  output  1  one-clk pulse when x becomes 0.

Function
REQ-015 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525); SHALL be computed at elaboration.
REQ-016 Internal pixel enable pix_en SHALL gate all counter advances; counters hold when pix_en=0.
REQ-017 h_cnt SHALL increment on pix_en and wrap from H_TOTAL-1 to 0.
REQ-018 v_cnt SHALL increment only on a pix_en where h_cnt=H_TOTAL-1, wrapping from V_TOTAL-1 to 0 (simultaneous h/v wrap lands on (0,0)).
REQ-019 Horizontal region FSM SHALL track states H_ACT, H_FRONT, H_SYNC_ST, H_BACK, advancing at h_cnt = H_ACTIVE, H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC and H_TOTAL (back to H_ACT); vertical FSM SHALL mirror it on v_cnt.
REQ-020 hsync SHALL be 0 exactly while the horizontal FSM is in H_SYNC_ST (h_cnt 656..751); vsync SHALL be 0 exactly while v_cnt is 490..491.
REQ-021 All outputs SHALL be registered, reflecting counter/FSM state with fixed latency of 1 clk, so x, y, video_on, hsync and vsync are mutually aligned.
REQ-022 frame_start and line_start SHALL be high for exactly one clk per event, never for a full pix_en period.
REQ-023 Counter arithmetic SHALL be 10-bit unsigned; no comparison SHALL depend on overflow.

Reset
REQ-024 While rst=1: h_cnt=0, v_cnt=0, FSMs in H_ACT/V_ACT, pix_en divider cleared.
REQ-025 Output reset values: x=0, y=0, video_on=0, hsync=1, vsync=1, frame_start=0, line_start=0.
REQ-026 Reset asserted mid-frame SHALL take effect on the next clk edge regardless of pix_en; first clk after release SHALL output x=0, y=0, video_on=1 with frame_start=1.

Configuration
REQ-027 Macro VGA_TIMING_PIX_DIV_EN defined: pix_en SHALL toggle, high on every second clk (first clk after reset release), for a 50 MHz clk giving 25 MHz pixel rate.
REQ-028 Macro undefined: pix_en SHALL be constant 1 (clk is the pixel clock); no divider flop SHALL exist.

Structure
REQ-029 Shared package vga_pkg SHALL hold the default timing constants, the region-state enum (H_ACT/H_FRONT/H_SYNC_ST/H_BACK) and the coordinate width constant (10).
REQ-030 One sub-module, timing_counter, SHALL implement a single wrapping counter with enable, terminal-count flag and region FSM; instantiated twice (horizontal, vertical).

Verification
REQ-031 Reset release, macro off -> x=0,y=0,frame_start=1 on first clk; x reaches 799 then 0 with y=1 and line_start=1 exactly 800 clks later.
REQ-032 Run one frame, macro off -> frame_start pulses exactly 420000 clks apart; hsync low count per line = 96, vsync low = 2 lines (1600 clks).
REQ-033 Check video_on -> high for exactly 640x480 = 307200 clks per frame, low at x=640 and y=480.
REQ-034 Macro on -> x advances every 2 clks; frame period 840000 clks; frame_start width 1 clk.
REQ-035 Assert rst for 1 clk at x=700, y=300 -> next clk outputs reset values, following clk x=0, y=0, frame_start=1.
REQ-036 Check boundary x=799, y=524 -> next pixel x=0, y=0, frame_start=1, line_start=1, vsync=1.
